// File: rtl/switch_led_ctrl_pkg.sv
// rtl/switch_led_ctrl_pkg.sv - shared LED mode codes and board timing defaults
package switch_led_ctrl_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'd0;
    localparam logic [1:0] MODE_TOGGLE = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;
    localparam logic [1:0] MODE_INVERT = 2'd3;

    // 10 ms debounce and 0.25 s blink half-period at a 50 MHz board clock
    localparam int DEF_DB_CYCLES  = 500000;
    localparam int DEF_BLINK_HALF = 12500000;

endpackage

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - one switch channel: synchroniser, debounce counter, rise pulse
module switch_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic stable,
    output logic rise
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    logic          sync0;
    logic          sync1;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            cnt      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sync0    <= sw;
            sync1    <= sync0;
            stable_d <= stable;
            rise     <= stable & ~stable_d;
            // any return to the accepted level restarts the hold window
            if (sync1 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                stable <= sync1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/switch_led_ctrl.sv
// rtl/switch_led_ctrl.sv - debounced switches driving LEDs in direct/toggle/blink/invert modes
module switch_led_ctrl
    import switch_led_ctrl_pkg::*;
#(
    parameter int N          = 16,
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int BLINK_HALF = DEF_BLINK_HALF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] switch,
    input  logic [1:0]   mode,
    output logic [N-1:0] sw_stable,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] led
);

    localparam int PW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

    logic [N-1:0]  tog;
    logic [PW-1:0] pre;
    logic          blink_ph;

    for (genvar i = 0; i < N; i++) begin : g_ch
        switch_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .sw     (switch[i]),
            .stable (sw_stable[i]),
            .rise   (sw_rise[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre      <= '0;
            blink_ph <= 1'b0;
        end else if (pre == PW'(BLINK_HALF - 1)) begin
            pre      <= '0;
            blink_ph <= ~blink_ph;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // toggle state runs in every mode so switching into toggle mode shows history
    always_ff @(posedge clk) begin
        if (rst) begin
            tog <= '0;
        end else begin
            tog <= tog ^ sw_rise;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else begin
            case (mode)
                MODE_DIRECT: led <= sw_stable;
                MODE_TOGGLE: led <= tog;
                MODE_BLINK:  led <= sw_stable & {N{blink_ph}};
                MODE_INVERT: led <= ~sw_stable;
                default:     led <= sw_stable;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_led_ctrl.sv
// tb/tb_switch_led_ctrl.sv - directed self-checking bench for switch_led_ctrl
module tb_switch_led_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] switch;
    logic [1:0] mode;
    logic [3:0] sw_stable;
    logic [3:0] sw_rise;
    logic [3:0] led;

    int n_checks = 0;
    int n_pass   = 0;

    int  m_cnt;
    logic m_ph;

    switch_led_ctrl #(
        .N          (4),
        .DB_CYCLES  (4),
        .BLINK_HALF (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .switch    (switch),
        .mode      (mode),
        .sw_stable (sw_stable),
        .sw_rise   (sw_rise),
        .led       (led)
    );

    always #5 clk = ~clk;

    // reference blink phase: counter 0..7 from reset, phase flips on wrap
    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0;
            m_ph  <= 1'b0;
        end else if (m_cnt == 7) begin
            m_cnt <= 0;
            m_ph  <= ~m_ph;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        logic rise_seen;
        logic [3:0] exp_led;

        rst = 1'b1;
        switch = 4'b1111;
        mode = 2'd0;
        tick(); tick(); tick();
        check("rst_stable", sw_stable, 4'b0000);
        check("rst_rise", sw_rise, 4'b0000);
        check("rst_led", led, 4'b0000);

        // power-up latency with all switches high
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("pu_stable_e%0d", e), sw_stable, (e >= 6) ? 4'b1111 : 4'b0000);
            check($sformatf("pu_rise_e%0d", e), sw_rise, (e == 7) ? 4'b1111 : 4'b0000);
            check($sformatf("pu_led_e%0d", e), led, (e >= 7) ? 4'b1111 : 4'b0000);
        end

        // drop channel 0, then bounce it before a clean press
        switch = 4'b1110;
        rise_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            rise_seen |= sw_rise[0];
        end
        check("fall_stable", sw_stable, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            switch[0] = ~switch[0];
            tick();
            rise_seen |= sw_rise[0];
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            rise_seen |= sw_rise[0];
        end
        check("bounce_no_rise", rise_seen, 1'b0);
        check("bounce_stable", sw_stable, 4'b1110);
        switch[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("bounce_s0_e%0d", e), sw_stable[0], (e >= 6) ? 1'b1 : 1'b0);
            check($sformatf("bounce_rise_e%0d", e), sw_rise[0], (e == 7) ? 1'b1 : 1'b0);
        end

        // blink mode
        mode = 2'd2;
        switch = 4'b0101;
        for (int i = 0; i < 10; i++) tick();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            exp_led = 4'b0101 & {4{m_ph}};
            tick();
            check($sformatf("blink_c%0d", i), led, exp_led);
        end

        // inverted mode, then back to direct
        mode = 2'd3;
        switch = 4'b0011;
        for (int i = 0; i < 10; i++) tick();
        check("invert_led", led, 4'b1100);
        mode = 2'd0;
        tick();
        check("inv_to_direct", led, 4'b0011);

        // clean slate for the toggle sequence
        switch = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("clear_led", led, 4'b0000);

        mode = 2'd1;
        tick();
        for (int p = 0; p < 3; p++) begin
            switch = 4'b0100;
            for (int i = 0; i < 10; i++) tick();
            check($sformatf("tog_press%0d", p), led, (p == 1) ? 4'b0000 : 4'b0100);
            switch = 4'b0000;
            for (int i = 0; i < 10; i++) tick();
            check($sformatf("tog_rel%0d", p), led, (p == 1) ? 4'b0000 : 4'b0100);
        end

        // reset in the middle of a debounce window with tog = 0100
        switch = 4'b1000;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_stable", sw_stable, 4'b0000);
        check("mid_rst_rise", sw_rise, 4'b0000);
        check("mid_rst_led", led, 4'b0000);
        rst = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (j <= 7) check($sformatf("post_rst_s3_j%0d", j), sw_stable[3], (j >= 6) ? 1'b1 : 1'b0);
            if (j <= 8) check($sformatf("post_rst_led_j%0d", j), led, 4'b0000);
        end
        check("post_rst_tog", led, 4'b1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/switch_led_ctrl.md
Name: switch_led_ctrl

Overview:
- Parametrised successor to the direct switch-to-LED path. Each of N slide-switch channels is synchronised and debounced, then drives its LED in one of four runtime-selectable modes: direct, toggle, blink, inverted.
- Sits between the board switch pins and the LED pins.
- Also exports per-channel debounced levels and rising-edge pulses for use by other demo logic.

Parameters:
- N, 16, number of switch/LED channels (1..32).
- DB_CYCLES, 500000, consecutive clk cycles a changed synchronised input must hold before it is accepted (>=2).
- BLINK_HALF, 12500000, clk cycles per blink half-period (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- switch  input  N  raw asynchronous switch levels.
- mode  input  2  LED mode: 0 direct, 1 toggle, 2 blink, 3 inverted; sampled every cycle.
- sw_stable  output  N  debounced switch levels.
- sw_rise  output  N  one-cycle pulse per channel on debounced 0->1.
- led  output  N  LED drive, active-high.

Behaviour:
- Reset is synchronous, active-high, and overrides everything. While rst=1 at a clk edge, these all clear to 0: sync flops, debounce counters, sw_stable, sw_rise, toggle state, blink prescaler, blink phase, led.
- Reset asserted mid-debounce discards the partial count. After release, channels whose switch is 1 need the full 2+DB_CYCLES cycles to report 1.
- Synchronisation: two-flop synchroniser per channel; its output is sw_sync.
- Debounce, per channel:
  - A counter of width $clog2(DB_CYCLES).
  - If sw_sync == sw_stable: counter <= 0.
  - Else if counter == DB_CYCLES-1: sw_stable <= sw_sync and counter <= 0.
  - Else: counter increments.
  - Any bounce back to the stable level clears the counter. Counter never wraps.
- Latency: a switch level change that persists is reflected on sw_stable DB_CYCLES+2 clk edges after the first edge that samples it.
- sw_rise[i]: registered; 1 for exactly the cycle following the edge at which sw_stable[i] went 0->1. Falls produce no pulse.
- Toggle state tog[i] flips on each sw_rise[i]=1. It is maintained in all modes; a mode change does not clear it.
- Blink prescaler:
  - Shared counter 0..BLINK_HALF-1, free-running from reset, wraps to 0.
  - blink_ph toggles when the counter wraps, giving a period of 2*BLINK_HALF cycles.
- LED output, registered one cycle after its inputs:
  - mode 0: led <= sw_stable.
  - mode 1: led <= tog.
  - mode 2: led <= sw_stable & {N{blink_ph}}.
  - mode 3: led <= ~sw_stable.
- Mode changes take effect on led one cycle after mode is sampled. There are no glitches between modes because led is a register.
- Channels are fully independent. Simultaneous changes on several channels are each handled in the same cycle.

Decomposition:
- Shared package holds:
  - Mode constants MODE_DIRECT=2'd0, MODE_TOGGLE=2'd1, MODE_BLINK=2'd2, MODE_INVERT=2'd3.
  - Default DB_CYCLES and BLINK_HALF for the board clock.
- One natural sub-module: switch_debounce. It is a single channel containing the synchroniser, counter, stable register and rise pulse, with parameter DB_CYCLES, and is instantiated N times via generate.
- Blink prescaler and LED mode mux stay in the top.

Test Plan (N=4, DB_CYCLES=4, BLINK_HALF=8):
- Reset with switch=4'b1111 held, release rst at edge 0 -> sw_stable=4'b0000 through edge 5, 4'b1111 at edge 6; sw_rise=4'b1111 for one cycle at edge 7; mode 0 led=4'b1111 at edge 7.
- Channel 0 bounces 1,0,1,0 on successive cycles, then holds 1 -> no sw_rise during bounce; sw_stable[0]=1 exactly 6 edges after the final 0->1 sample.
- mode=1, three clean presses (rise then fall, each phase held 10 cycles) on channel 2 -> led[2] sequence 1,0,1; other LEDs unchanged.
- mode=2, switch=4'b0101 stable -> led toggles between 4'b0101 and 4'b0000 every 8 cycles; led[1], led[3] always 0.
- mode=3, switch=4'b0011 stable -> led=4'b1100. Switch mode 3->0 at edge t -> led=4'b0011 at edge t+1, with no intermediate value.
- Assert rst for one cycle mid-debounce (counter=2) and mid-toggle state tog=4'b0100 -> all outputs 0 next edge, tog cleared, full DB_CYCLES+2 latency required again.
